logs_pwm_decoder: RTL and testbench

- Receiver for the 1-bit PWM audio line produced by the mixer.
- Recovers the per-period level (the mixer's input popcount) from the serial duty cycle.
- Locks to PWM period boundaries by tracking the line's falling edge.
- Sits on the test/loopback side of the design: it checks mixer output in-chip and feeds a level-meter register.

---
 rtl/logs_pwm_decoder.sv | 166 ++++++++++++++++
 tb/tb_logs_pwm_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/logs_pwm_decoder.sv
// Purpose: recovers the per-period level from the mixer's 1-bit PWM audio line, locking to period boundaries via falling edges.
// Latency: level/level_valid are registered one cycle after the last window sample (+2 cycles with the input synchronizer).
// Backpressure: none; level_valid is a one-cycle strobe and level holds its value until the next strobe.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   audio_in     PWM line from the mixer
//   level        recovered level (K bits), held between updates
//   level_valid  one-cycle strobe, level updated this cycle
//   locked       high while the period phase is tracked
//
// Build option: define LOGS_PWMDEC_SYNC_EN to pass audio_in through a 2-flop
// synchronizer before edge detection (for asynchronous or pin-sourced inputs).

`timescale 1ns/1ps

module logs_pwm_decoder #(
   parameter int K         = 2,
   parameter int LOCK_MISS = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         audio_in,
   output logic [K-1:0] level,
   output logic         level_valid,
   output logic         locked
);

   typedef enum logic {HUNT, LOCKED} state_t;

   localparam logic [K-1:0] LAST_POS = {K{1'b1}};
   localparam logic [2:0]   MISS_LIM = 3'(LOCK_MISS);

   logic s;
   logic s_d;
   logic fe;

`ifdef LOGS_PWMDEC_SYNC_EN
   logic sync_q1;
   logic sync_q2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= audio_in;
         sync_q2 <= sync_q1;
      end
   end

   assign s = sync_q2;
`else
   assign s = audio_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d <= 1'b0;
      end else begin
         s_d <= s;
      end
   end

   // The mixer puts its high samples at the end of the period, so a falling
   // edge is the first (low) sample of the next window.
   assign fe = s_d & ~s;

   state_t       state, state_nxt;
   logic [K-1:0] phase, phase_nxt;
   logic [K:0]   acc, acc_nxt;
   logic [2:0]   miss, miss_nxt;
   logic [K-1:0] level_nxt;
   logic         level_valid_nxt;
   logic         locked_nxt;
   logic [K:0]   acc_sum;
   logic [2:0]   miss_inc;

   assign acc_sum  = acc + {{K{1'b0}}, s};
   assign miss_inc = miss + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         phase       <= '0;
         acc         <= '0;
         miss        <= '0;
         level       <= '0;
         level_valid <= 1'b0;
         locked      <= 1'b0;
      end else begin
         state       <= state_nxt;
         phase       <= phase_nxt;
         acc         <= acc_nxt;
         miss        <= miss_nxt;
         level       <= level_nxt;
         level_valid <= level_valid_nxt;
         locked      <= locked_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      phase_nxt       = phase;
      acc_nxt         = acc;
      miss_nxt        = miss;
      level_nxt       = level;
      level_valid_nxt = 1'b0;
      locked_nxt      = locked;

      case (state)
         HUNT: begin
            locked_nxt = 1'b0;
            if (fe) begin
               // Current sample is window position 0 (and is low).
               state_nxt  = LOCKED;
               phase_nxt  = K'(1);
               acc_nxt    = '0;
               miss_nxt   = '0;
               locked_nxt = 1'b1;
            end
         end

         LOCKED: begin
            locked_nxt = 1'b1;
            phase_nxt  = phase + K'(1);
            // Position 0 restarts the count with the current sample.
            acc_nxt    = (phase == '0) ? {{K{1'b0}}, s} : acc_sum;

            if (phase == LAST_POS) begin
               // Level is the number of low samples minus one, i.e.
               // (2^K-1) - highs, wrapped to K bits.
               level_nxt       = LAST_POS - acc_sum[K-1:0];
               level_valid_nxt = 1'b1;
            end

            if (fe) begin
               if (phase == '0) begin
                  miss_nxt = '0;
               end else if (miss_inc >= MISS_LIM) begin
                  // Too many misaligned edges: abandon this window without
                  // a strobe. This edge is not reused; relock waits for the
                  // next falling edge.
                  state_nxt       = HUNT;
                  locked_nxt      = 1'b0;
                  phase_nxt       = '0;
                  acc_nxt         = '0;
                  miss_nxt        = '0;
                  level_nxt       = level;
                  level_valid_nxt = 1'b0;
               end else begin
                  // Tolerated glitch: phase is not re-aligned, the current
                  // window still completes.
                  miss_nxt = miss_inc;
               end
            end
         end

         default: begin
            state_nxt = HUNT;
         end
      endcase
   end

endmodule

// File: tb/tb_logs_pwm_decoder.sv
`timescale 1ns/1ps

module tb_logs_pwm_decoder;

`ifdef LOGS_PWMDEC_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int lvl;   // -1: value not checked
      int at;    // -1: cycle not checked
   } exp_t;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       audio2 = 1'b0;
   logic       audio3 = 1'b0;
   logic [1:0] level2;
   logic       level_valid2;
   logic       locked2;
   logic [2:0] level3;
   logic       level_valid3;
   logic       locked3;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q2[$];
   exp_t q3[$];
   exp_t e2;
   exp_t e3;

   logs_pwm_decoder #(.K(2), .LOCK_MISS(2)) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .audio_in    (audio2),
      .level       (level2),
      .level_valid (level_valid2),
      .locked      (locked2)
   );

   logs_pwm_decoder #(.K(3), .LOCK_MISS(2)) dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .audio_in    (audio3),
      .level       (level3),
      .level_valid (level_valid3),
      .locked      (locked3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboards: every strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && level_valid2 === 1'b1) begin
         check("k2_strobe_expected", 32'(q2.size() != 0), 1);
         if (q2.size() != 0) begin
            e2 = q2.pop_front();
            if (e2.lvl >= 0) check("k2_level", 32'(level2), e2.lvl);
            if (e2.at >= 0)  check("k2_strobe_cycle", cyc, e2.at);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && level_valid3 === 1'b1) begin
         check("k3_strobe_expected", 32'(q3.size() != 0), 1);
         if (q3.size() != 0) begin
            e3 = q3.pop_front();
            if (e3.lvl >= 0) check("k3_level", 32'(level3), e3.lvl);
            if (e3.at >= 0)  check("k3_strobe_cycle", cyc, e3.at);
         end
      end
   end

   task automatic drive_bit(input int k3, input logic b);
      if (k3 != 0) audio3 = b;
      else         audio2 = b;
      @(posedge clk);
      #1;
   endtask

   // One mixer period for popcount 'sum': sum+1 lows then the highs.
   // push: 0 none, 1 exact value and cycle, 2 strobe expected but unchecked.
   task automatic drive_period(input int k3, input int sum, input int push, input int lock_at);
      int   n;
      exp_t e;
      n     = (k3 != 0) ? 8 : 4;
      e.lvl = (push == 1) ? sum : -1;
      e.at  = (push == 1) ? cyc + n + LAT : -1;
      if (push != 0) begin
         if (k3 != 0) q3.push_back(e);
         else         q2.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         drive_bit(k3, logic'(i >= sum + 1));
         if (i + 1 == lock_at) begin
            if (k3 != 0) check("k3_lock_low_before", 32'(locked3), 0);
            else         check("k2_lock_low_before", 32'(locked2), 0);
         end
         if (i == lock_at) begin
            if (k3 != 0) check("k3_lock_rise", 32'(locked3), 1);
            else         check("k2_lock_rise", 32'(locked2), 1);
         end
      end
   endtask

   task automatic drive_seq(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) drive_bit(0, bits[i]);
   endtask

   task automatic push2(input int lvl, input int at);
      exp_t e;
      e.lvl = lvl;
      e.at  = at;
      q2.push_back(e);
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_level2", 32'(level2), 0);
      check("rst_valid2", 32'(level_valid2), 0);
      check("rst_locked2", 32'(locked2), 0);
      check("rst_locked3", 32'(locked3), 0);
      rst_n = 1'b1;
      drive_bit(0, 1'b0);

      // Sum=1: lock on first falling edge, level 1 every period
      drive_period(0, 1, 0, -1);
      check("k2_unlocked_before_fe", 32'(locked2), 0);
      drive_period(0, 1, 1, LAT);
      repeat (3) drive_period(0, 1, 1, -1);
      check("k2_locked_sum1", 32'(locked2), 1);

      // Sum=0 then sum=3 (all-low periods are not misses)
      for (int p = 0; p < 3; p++) begin
         drive_period(0, 0, 1, -1);
         check("k2_locked_sum0", 32'(locked2), 1);
      end
      for (int p = 0; p < 3; p++) begin
         drive_period(0, 3, 1, -1);
         check("k2_locked_sum3", 32'(locked2), 1);
      end

      // Single one-cycle slip, then original phase
      drive_period(0, 1, 1, -1);
      drive_period(0, 1, 1, -1);
      push2(-1, -1);
      drive_seq(8'b0000_0011, 5);
      push2(1, cyc + 3 + LAT);
      drive_seq(8'b0000_0001, 3);
      check("k2_locked_after_slip", 32'(locked2), 1);
      drive_period(0, 1, 1, -1);
      drive_period(0, 1, 1, -1);
      check("k2_locked_slip_recovered", 32'(locked2), 1);

      // Persistent slip: second misaligned edge drops lock, no strobe
      push2(-1, -1);
      drive_seq(8'b0000_0011, 5);
      drive_period(0, 1, 2, -1);
      drive_period(0, 1, 0, -1);
      check("k2_lock_dropped", 32'(locked2), 0);
      drive_period(0, 1, 1, -1);
      check("k2_relocked", 32'(locked2), 1);
      drive_period(0, 1, 1, -1);
      drive_period(0, 1, 1, -1);

      // Asynchronous reset mid-window
      check("k2_level_hold_pre_reset", 32'(level2), 1);
      drive_bit(0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("k2_async_rst_level", 32'(level2), 0);
      check("k2_async_rst_valid", 32'(level_valid2), 0);
      check("k2_async_rst_locked", 32'(locked2), 0);
      q2.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_period(0, 1, 0, -1);
      check("k2_unlocked_after_rst", 32'(locked2), 0);
      drive_period(0, 1, 1, LAT);
      drive_period(0, 1, 1, -1);
      repeat (LAT + 2) drive_bit(0, 1'b0);
      check("k2_queue_drained", q2.size(), 0);

      // Quiesce the K=2 instance before exercising K=3
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_bit(1, 1'b0);

      // K=3, sum=5
      drive_period(1, 5, 0, -1);
      check("k3_unlocked_before_fe", 32'(locked3), 0);
      drive_period(1, 5, 1, LAT);
      drive_period(1, 5, 1, -1);
      drive_period(1, 5, 1, -1);
      check("k3_locked", 32'(locked3), 1);
      repeat (LAT + 2) drive_bit(1, 1'b0);
      check("k3_queue_drained", q3.size(), 0);
      check("k2_idle_unlocked", 32'(locked2), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
